// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: word size, canonical NOP,
// default reset vector and the {pc, instr} entry carried through the fetch buffer.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction memory is word addressed; the two low byte-offset bits are always dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries. Read and write pointers
// wrap naturally (depth is a power of two); a separate count register gives
// full/empty without pointer-comparison ambiguity. Flush empties it in one cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Entry storage: data only, never reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything, including a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side initiator: owns the fetch PC, reads the combinational instruction
// memory, buffers {pc, instr} pairs and hands them to decode over valid/ready.
// A redirect flushes the buffer and restarts fetch at the (word-aligned) target.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] last_pc;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  assign imem_addr = word_align(fetch_pc);

  // A full buffer still takes a new entry when its head leaves in the same cycle.
  assign id_valid = ~empty;
  assign pop      = id_valid & id_ready;
  assign push     = ~redirect_valid & (~full | pop);

  assign wdata = '{pc: imem_addr, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Fetch PC: reset vector, redirect target, or sequential advance (wraps modulo 2^32).
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= word_align(RESET_PC);
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Remember the most recently presented PC so id_pc holds steady while the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc <= '0;
    end else if (id_valid) begin
      last_pc <= head.pc;
    end
  end

  // Decode-side view: head entry when valid, otherwise NOP with the held PC.
  always_comb begin
    id_instr    = INSTR_NOP;
    id_pc       = last_pc;
    if (id_valid) begin
      id_instr = head.instr;
      id_pc    = head.pc;
    end
    id_pc_plus4 = id_pc + 32'd4;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: combinational ROM model with the preload image,
// a scoreboard queue of expected deliveries consumed by a handshake monitor,
// and one task per scenario with its own targeted checks.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  exp_t sb [$];
  exp_t mon_e;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h00000293;
      30'd1:   return 32'h00500313;
      30'd2:   return 32'h00b324b3;
      30'd3:   return 32'h0062a433;
      30'd4:   return 32'h0092b233;
      30'd5:   return 32'h004000ef;
      30'd6:   return 32'h0002c283;
      30'd7:   return 32'h00c32023;
      30'd8:   return 32'h00530463;
      30'd9:   return 32'h00531463;
      default: return 32'h00000000;
    endcase
  endfunction

  // Instruction memory answers in the same cycle.
  always_comb imem_rdata = rom(imem_addr);

  initial clk = 1'b0;
  // 10-unit clock.
  always #5 clk = ~clk;

  // Scoreboard: every accepted handshake must match the next expected entry.
  always @(negedge clk) begin
    if (mon_en && !rst && id_valid && id_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: delivered pc=%h instr=%h, required no delivery", id_pc, id_instr);
      end else begin
        mon_e = sb.pop_front();
        if (id_pc !== mon_e.pc || id_instr !== mon_e.instr || id_pc_plus4 !== mon_e.pc + 32'd4) begin
          n_fail++;
          $display("FAIL sb_entry: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                   id_pc, id_instr, id_pc_plus4, mon_e.pc, mon_e.instr, mon_e.pc + 32'd4);
        end
      end
    end
  end

  task automatic sb_push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rom(pc);
    sb.push_back(e);
  endtask

  task automatic apply_reset(input logic rdy);
    mon_en = 1'b0;
    sb.delete();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = rdy;
    rst            = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", id_valid); end
    n_checks++; if (id_instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h, required %h", id_instr, NOP); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h, required 0", id_pc); end
    n_checks++; if (id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4: got %h, required 4", id_pc_plus4); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h, required 0", imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    for (int i = 0; i < 8; i++) sb_push(32'(4 * i));
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b, required 0", id_valid); end
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL stream_c1: got valid=%b pc=%h, required valid=1 pc=0", id_valid, id_pc); end
    for (int c = 0; c < 30 && sb.size() != 0; c++) @(posedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stream_drain: %0d left, required 0", sb.size()); end
    #1; mon_en = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_stall();
    apply_reset(1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b, required 1", id_valid); end
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr: got %h, required 00000008", imem_addr); end
    n_checks++; if (id_instr !== 32'h00000293) begin n_fail++; $display("FAIL stall_instr: got %h, required 00000293", id_instr); end
    for (int i = 0; i < 5; i++) sb_push(32'(4 * i));
    mon_en = 1'b1;
    @(posedge clk); #1;
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL stall_release%0d: got valid=%b pc=%h, required valid=1 pc=%h", i, id_valid, id_pc, 32'(4 * i));
      end
    end
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stall_drain: %0d left, required 0", sb.size()); end
    #1; mon_en = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b0);
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) sb_push(32'(4 * i));
    mon_en = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (id_valid !== 1'b1 || imem_addr !== 32'(8 + 4 * i)) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got valid=%b addr=%h, required valid=1 addr=%h", i, id_valid, imem_addr, 32'(8 + 4 * i));
      end
    end
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d left, required 0", sb.size()); end
    #1; mon_en = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_redirect();
    bit found;
    apply_reset(1'b1);
    sb_push(32'h0); sb_push(32'h4); sb_push(32'h1C); sb_push(32'h20); sb_push(32'h24);
    mon_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (id_valid === 1'b1 && id_pc === 32'h4) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL redir_head4: got no head pc=4 within 10 cycles, required it"); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_001E;
    @(posedge clk); #1;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h4) begin
      n_fail++; $display("FAIL redir_bubble: got valid=%b instr=%h pc=%h, required valid=0 instr=%h pc=4", id_valid, id_instr, id_pc, NOP);
    end
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1C || id_instr !== 32'h00c32023) begin
      n_fail++; $display("FAIL redir_target: got valid=%b pc=%h instr=%h, required valid=1 pc=0000001c instr=00c32023", id_valid, id_pc, id_instr);
    end
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL redir_drain: %0d left, required 0", sb.size()); end
    #1; mon_en = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit found;
    apply_reset(1'b1);
    sb_push(32'h0); sb_push(32'hFFFF_FFFC); sb_push(32'h0); sb_push(32'h4);
    mon_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (id_valid === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || id_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_head0: got found=%b pc=%h, required found=1 pc=0", found, id_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_bubble: got valid=%b, required 0", id_valid); end
    @(negedge clk);
    n_checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc4: got pc=%h pc4=%h, required pc=fffffffc pc4=00000000", id_pc, id_pc_plus4);
    end
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_drain: %0d left, required 0", sb.size()); end
    #1; mon_en = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset(1'b0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b, required 0", id_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mrst_addr: got %h, required 0", imem_addr); end
    n_checks++; if (id_instr !== NOP || id_pc !== 32'h0) begin n_fail++; $display("FAIL mrst_head: got instr=%h pc=%h, required instr=%h pc=0", id_instr, id_pc, NOP); end
    @(posedge clk); #1;
    rst = 1'b0;
    id_ready = 1'b1;
    sb_push(32'h0); sb_push(32'h4);
    mon_en = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mrst_drain: %0d left, required 0", sb.size()); end
    #1; mon_en = 1'b0; id_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_redirect();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation reached 100000 time units, required completion earlier");
    $fatal(1, "timeout");
  end

endmodule
